// File: rtl/alu_pkg.sv
// alu_pkg: opcode/state enums and opcode width shared by the ALU slice
package alu_pkg;
  localparam int OP_W = 3;
  typedef enum logic [2:0] {OP_ADD = 3'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shared shift-add multiply / restoring divide datapath, one bit per step
module alu_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);
  logic [WIDTH-1:0] hi_q, lo_q, m_q, src_hi, src_lo, src_m;
  logic [WIDTH:0] add_s, sub_s;
  // acc_* is the state after one more step; load folds the first step into the accept edge
  always_comb begin
    src_hi = load ? '0 : hi_q;
    src_lo = load ? (is_div ? a : b) : lo_q;
    src_m  = load ? (is_div ? b : a) : m_q;
    add_s  = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
    sub_s  = {src_hi, src_lo[WIDTH-1]} - {1'b0, src_m};
    acc_hi = is_div ? (sub_s[WIDTH] ? {src_hi[WIDTH-2:0], src_lo[WIDTH-1]} : sub_s[WIDTH-1:0])
                    : add_s[WIDTH:1];
    acc_lo = is_div ? {src_lo[WIDTH-2:0], ~sub_s[WIDTH]} : {add_s[0], src_lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else if (load || step) begin
      hi_q <= acc_hi;
      lo_q <= acc_lo;
      m_q  <= src_m;
    end
  end
endmodule

// File: rtl/alu_multicycle_param.sv
// alu_multicycle_param: handshaked multi-cycle ALU with iterative MUL/DIV, tag pass-through and error flag
module alu_multicycle_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0] op_q;
  logic [TAG_W-1:0] tag_q;
  logic accept, is_iter, last, is_div;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] imm_lo, imm_hi, acc_lo, acc_hi;
  logic imm_err;
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == S_IDLE ? (accept ? (is_iter ? S_BUSY : S_DONE) : S_IDLE)
              : state == S_BUSY ? (last ? S_DONE : S_BUSY)
              : state == S_DONE ? (out_ready ? S_IDLE : S_DONE)
              : S_IDLE;
  end
  always_comb begin
    in_ready  = state == S_IDLE;
    out_valid = state == S_DONE;
  end
  always_comb begin
    accept  = in_valid && in_ready;
    is_iter = in_op == OP_MUL || (in_op == OP_DIV && in_b != '0);
    last    = cnt == CNT_W'(WIDTH - 1);
    is_div  = state == S_IDLE ? in_op == OP_DIV : op_q == OP_DIV;
    sum     = {1'b0, in_a} + {1'b0, in_b};
    dif     = {1'b0, in_a} - {1'b0, in_b};
    imm_lo  = '0;
    imm_hi  = '0;
    imm_err = 1'b0;
    case (in_op)
      OP_ADD: begin imm_lo = sum[WIDTH-1:0]; imm_hi = WIDTH'(sum[WIDTH]); end
      OP_SUB: begin imm_lo = dif[WIDTH-1:0]; imm_hi = WIDTH'(dif[WIDTH]); end
      OP_AND: imm_lo = in_a & in_b;
      OP_OR:  imm_lo = in_a | in_b;
      OP_XOR: imm_lo = in_a ^ in_b;
      OP_DIV: begin imm_lo = '1; imm_hi = in_a; imm_err = 1'b1; end
      default: imm_err = 1'b1;
    endcase
  end
  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .load(accept && is_iter), .step(state == S_BUSY),
    .is_div(is_div), .a(in_a), .b(in_b), .acc_hi(acc_hi), .acc_lo(acc_lo)
  );
  // cnt holds the number of iterations already done while BUSY, so it runs 1..WIDTH-1
  always_ff @(posedge clk) begin
    if (rst) begin
      out_lo  <= '0;
      out_hi  <= '0;
      out_err <= 1'b0;
      out_tag <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      cnt     <= '0;
    end else if (accept && is_iter) begin
      op_q  <= in_op;
      tag_q <= in_tag;
      cnt   <= CNT_W'(1);
    end else if (accept) begin
      out_lo  <= imm_lo;
      out_hi  <= imm_hi;
      out_err <= imm_err;
      out_tag <= in_tag;
    end else if (state == S_BUSY) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
      if (last) begin
        out_lo  <= acc_lo;
        out_hi  <= acc_hi;
        out_err <= 1'b0;
        out_tag <= tag_q;
      end
    end
  end
endmodule
